// File: rtl/sc_enc_pkg.sv
// sc_enc_pkg: op enum, RV32I opcode/funct3 constants and range-check helper for sc_inst_encoder.
package sc_enc_pkg;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRAI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_JAL, OP_JALR
    } op_e;

    typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_e;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0]  F7_ALT   = 7'b0100000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when v, read as signed, fits a two's-complement field of the given width.
    function automatic logic fits(input logic [31:0] v, input int bits);
        int lim;
        lim = 1 << (bits - 1);
        return $signed(v) >= -lim && $signed(v) < lim;
    endfunction
endpackage

// File: rtl/sc_enc_fifo.sv
// sc_enc_fifo: synchronous FIFO with full/empty flags; DEPTH must be a power of two >= 2.
module sc_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;

    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign dout = mem[rp[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/sc_inst_encoder.sv
// sc_inst_encoder: encodes symbolic RV32I instructions into machine words streamed with byte addresses.
// Define ENC_NOP_PAD_EN to pad each program with NOPs up to a PAD_ALIGN-word boundary.
module sc_inst_encoder
    import sc_enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          PAD_ALIGN = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        done
);
    state_e state;
    logic full, empty, acc, ok, pop, push, pad_push, pad_done;
    logic i_ok, b_ok, j_ok;
    logic [31:0] word, din;

    assign in_ready = state == LOAD && !full;
    assign acc = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    assign push = (acc && ok) || pad_push;
    assign din = pad_push ? NOP_WORD : word;
    assign i_ok = fits(in_imm, 12);
    assign b_ok = fits(in_imm, 13) && !in_imm[0];
    assign j_ok = fits(in_imm, 21) && !in_imm[0];

    always_comb begin
        {word, ok} = {NOP_WORD, 1'b1};
        case (in_op)
            OP_ADD:  word = {7'h00, in_rs2, in_rs1, F3_ADD, in_rd, OPC_R};
            OP_SUB:  word = {F7_ALT, in_rs2, in_rs1, F3_ADD, in_rd, OPC_R};
            OP_AND:  word = {7'h00, in_rs2, in_rs1, F3_AND, in_rd, OPC_R};
            OP_OR:   word = {7'h00, in_rs2, in_rs1, F3_OR, in_rd, OPC_R};
            OP_XOR:  word = {7'h00, in_rs2, in_rs1, F3_XOR, in_rd, OPC_R};
            OP_SLL:  word = {7'h00, in_rs2, in_rs1, F3_SLL, in_rd, OPC_R};
            OP_SRL:  word = {7'h00, in_rs2, in_rs1, F3_SR, in_rd, OPC_R};
            OP_SRA:  word = {F7_ALT, in_rs2, in_rs1, F3_SR, in_rd, OPC_R};
            OP_ADDI: {word, ok} = {in_imm[11:0], in_rs1, F3_ADD, in_rd, OPC_I, i_ok};
            OP_ANDI: {word, ok} = {in_imm[11:0], in_rs1, F3_AND, in_rd, OPC_I, i_ok};
            OP_ORI:  {word, ok} = {in_imm[11:0], in_rs1, F3_OR, in_rd, OPC_I, i_ok};
            OP_XORI: {word, ok} = {in_imm[11:0], in_rs1, F3_XOR, in_rd, OPC_I, i_ok};
            OP_SLLI: {word, ok} = {7'h00, in_imm[4:0], in_rs1, F3_SLL, in_rd, OPC_I, in_imm[31:5] == 27'd0};
            OP_SRAI: {word, ok} = {F7_ALT, in_imm[4:0], in_rs1, F3_SR, in_rd, OPC_I, in_imm[31:5] == 27'd0};
            OP_LW:   {word, ok} = {in_imm[11:0], in_rs1, F3_W, in_rd, OPC_LW, i_ok};
            OP_SW:   {word, ok} = {in_imm[11:5], in_rs2, in_rs1, F3_W, in_imm[4:0], OPC_SW, i_ok};
            OP_BEQ:  {word, ok} = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ, in_imm[4:1], in_imm[11], OPC_BR, b_ok};
            OP_BNE:  {word, ok} = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BNE, in_imm[4:1], in_imm[11], OPC_BR, b_ok};
            OP_LUI:  {word, ok} = {in_imm[19:0], in_rd, OPC_LUI, in_imm[31:20] == 12'd0};
            OP_JAL:  {word, ok} = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL, j_ok};
            OP_JALR: {word, ok} = {in_imm[11:0], in_rs1, F3_ADD, in_rd, OPC_JALR, i_ok};
            default: ok = 1'b0;
        endcase
    end

`ifdef ENC_NOP_PAD_EN
    // Words pushed since the last BASE_ADDR reload; padding tops this up to a PAD_ALIGN multiple.
    logic [31:0] wcnt;
    assign pad_done = (wcnt & (PAD_ALIGN - 1)) == 0;
    assign pad_push = state == DRAIN && !pad_done && !full;
    always_ff @(posedge clock) begin
        if (reset || state == DONE) wcnt <= '0;
        else if (push) wcnt <= wcnt + 32'd1;
    end
`else
    assign pad_push = 1'b0;
    assign pad_done = PAD_ALIGN > 0;
`endif

    sc_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(out_word),
        .full(full),
        .empty(empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
            out_addr <= BASE_ADDR;
            err <= 1'b0;
            err_count <= '0;
            done <= 1'b0;
        end else begin
            err <= acc && !ok;
            done <= 1'b0;
            if (acc && !ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (pop) out_addr <= out_addr + 32'd4;
            case (state)
                LOAD: if (acc && in_last) state <= DRAIN;
                DRAIN: if (empty && pad_done) begin
                    state <= DONE;
                    done <= 1'b1;
                end
                default: begin
                    state <= LOAD;
                    out_addr <= BASE_ADDR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_inst_encoder.sv
// tb_sc_inst_encoder: table-driven vectors plus hand sequences, checked through an output scoreboard.
module tb_sc_inst_encoder;
    import sc_enc_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ok;
    } vec_t;

    logic clock = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
    logic in_ready, out_valid, err, done;
    logic [4:0] in_op = 0, in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [31:0] in_imm = 0, out_word, out_addr;
    logic [7:0] err_count;

    int checks = 0, errors = 0;
    logic [63:0] q[$];
    logic [31:0] exp_addr = 0;
    logic [7:0] exp_errs = 0;

    sc_inst_encoder dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .err(err), .err_count(err_count), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [4:0] op, rd, rs1, rs2, input logic [31:0] imm, word, input logic ok);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.word = word; v.ok = ok;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h at %h expected none", out_word, out_addr);
                end else begin
                    e = q.pop_front();
                    check("word", out_word, e[63:32]);
                    check("addr", out_addr, e[31:0]);
                end
            end
        end
    endtask

    // Called at posedge+1; holds the beat until accepted, then checks the err response.
    task automatic send(input vec_t v, input logic last);
        int n = 0;
        in_valid = 1; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_imm = v.imm; in_last = last;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 0;
            in_last = 0;
            return;
        end
        if (v.ok) begin
            q.push_back({v.word, exp_addr});
            exp_addr += 4;
        end else if (exp_errs != 8'hFF) exp_errs++;
        @(posedge clock);
        #1;
        in_valid = 0;
        in_last = 0;
        check("err_pulse", err, !v.ok);
        if (!v.ok) check("err_count", err_count, exp_errs);
        if (last) check("drain_ready", in_ready, 0);
    endtask

    task automatic finish_prog();
        int n = 0;
`ifdef ENC_NOP_PAD_EN
        while (exp_addr % 16 != 0) begin
            q.push_back({NOP_WORD, exp_addr});
            exp_addr += 4;
        end
`endif
        while (done !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("done", done, 1);
        check("drained", q.size(), 0);
        @(posedge clock);
        #1;
        check("done_pulse", done, 0);
        check("addr_reload", out_addr, 32'd0);
        check("ready_reload", in_ready, 1);
        exp_addr = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1;
        q.delete();
        exp_addr = 0;
        exp_errs = 0;
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        vec_t tbl[$];
        fork
            monitor();
        join_none
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_done", done, 0);

        out_ready = 1;
        send(mk(OP_ADD, 3, 1, 2, 0, 32'h002081B3, 1), 1);
        finish_prog();

        send(mk(OP_SUB, 5, 6, 7, 0, 32'h407302B3, 1), 0);
        send(mk(OP_ADDI, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1), 1);
        finish_prog();

        send(mk(OP_ADDI, 1, 0, 0, 32'd2048, 0, 0), 0);
        send(mk(OP_BEQ, 0, 1, 2, 32'd3, 0, 0), 1);
        check("err_count_two", err_count, 8'd2);
        finish_prog();

        tbl.push_back(mk(OP_AND, 4, 5, 6, 0, 32'h0062F233, 1));
        tbl.push_back(mk(OP_OR, 7, 8, 9, 0, 32'h009463B3, 1));
        tbl.push_back(mk(OP_XOR, 10, 11, 12, 0, 32'h00C5C533, 1));
        tbl.push_back(mk(OP_ADDI, 1, 0, 0, 32'h800, 0, 0));
        tbl.push_back(mk(OP_SLL, 1, 2, 3, 0, 32'h003110B3, 1));
        tbl.push_back(mk(OP_SRL, 1, 2, 3, 0, 32'h003150B3, 1));
        tbl.push_back(mk(OP_SRA, 1, 2, 3, 0, 32'h403150B3, 1));
        tbl.push_back(mk(OP_ANDI, 2, 3, 0, 32'h0F0, 32'h0F01F113, 1));
        tbl.push_back(mk(OP_ORI, 2, 3, 0, 32'hFFFFF800, 32'h8001E113, 1));
        tbl.push_back(mk(OP_XORI, 2, 3, 0, 32'd2047, 32'h7FF1C113, 1));
        tbl.push_back(mk(OP_SLLI, 4, 5, 0, 32'd31, 32'h01F29213, 1));
        tbl.push_back(mk(OP_SLLI, 4, 5, 0, 32'd32, 0, 0));
        tbl.push_back(mk(OP_SRAI, 4, 5, 0, 32'd3, 32'h4032D213, 1));
        tbl.push_back(mk(OP_LW, 6, 2, 0, 32'd8, 32'h00812303, 1));
        tbl.push_back(mk(OP_SW, 0, 2, 6, 32'd12, 32'h00612623, 1));
        tbl.push_back(mk(OP_SW, 0, 2, 6, 32'hFFFFF7FF, 0, 0));
        tbl.push_back(mk(OP_BNE, 0, 3, 4, 32'd8, 32'h00419463, 1));
        tbl.push_back(mk(OP_BEQ, 0, 0, 0, 32'hFFE, 32'h7E000FE3, 1));
        tbl.push_back(mk(OP_BEQ, 0, 0, 0, 32'h1000, 0, 0));
        tbl.push_back(mk(OP_JAL, 1, 0, 0, 32'h800, 32'h001000EF, 1));
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 32'hFFF00000, 32'h8000006F, 1));
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 32'h00100000, 0, 0));
        tbl.push_back(mk(OP_JALR, 0, 1, 0, 0, 32'h00008067, 1));
        tbl.push_back(mk(OP_LUI, 1, 0, 0, 32'hFFFFF, 32'hFFFFF0B7, 1));
        tbl.push_back(mk(OP_LUI, 1, 0, 0, 32'h100000, 0, 0));
        tbl.push_back(mk(5'd21, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_BEQ, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1));
        tbl.push_back(mk(OP_LUI, 5, 0, 0, 32'h12345, 32'h123452B7, 1));
        for (int i = 0; i < tbl.size(); i++) send(tbl[i], i == tbl.size() - 1);
        finish_prog();

        out_ready = 0;
        for (int i = 1; i <= 4; i++)
            send(mk(OP_ADD, i[4:0], 1, 2, 0, 32'h00208033 | (i << 7), 1), 0);
        check("full_blocks", in_ready, 0);
        check("full_valid", out_valid, 1);
        fork
            begin
                send(mk(OP_ADD, 5, 1, 2, 0, 32'h002082B3, 1), 0);
                send(mk(OP_ADD, 6, 1, 2, 0, 32'h00208333, 1), 1);
            end
            begin
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1;
            end
        join
        finish_prog();

        for (int i = 0; i < 260; i++) send(mk(OP_ADDI, 1, 0, 0, 32'h800, 0, 0), i == 259);
        check("err_sat", err_count, 8'hFF);
        finish_prog();

        out_ready = 0;
        send(mk(OP_ADD, 3, 1, 2, 0, 32'h002081B3, 1), 0);
        send(mk(OP_SUB, 5, 6, 7, 0, 32'h407302B3, 1), 1);
        repeat (2) @(posedge clock);
        do_reset();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_addr", out_addr, 32'd0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_errs", err_count, 0);
        out_ready = 1;
        send(mk(OP_XOR, 10, 11, 12, 0, 32'h00C5C533, 1), 1);
        finish_prog();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_inst_encoder.md
Name: sc_inst_encoder

Overview:
- Inverse of the single-cycle control/decode path: accepts symbolic RV32I instructions (op enum, rd, rs1, rs2, imm) and produces 32-bit machine words.
- Encoded words are buffered in a small FIFO and streamed out with sequential word addresses for loading instruction memory.
- Covers the same 21-instruction subset the single-cycle CPU executes.
- Sits between the test/boot loader and the instruction-memory write port.

Parameters:
- DEPTH, 4, output FIFO depth in words (power of two, >=2).
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- PAD_ALIGN, 4, word alignment used by the optional pad feature (power of two).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  symbolic instruction present.
- in_ready  out  1  encoder can accept.
- in_op  in  5  op enum (package).
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate; for LUI, the upper-20 value.
- in_last  in  1  marks the final instruction of a program.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts.
- out_word  out  32  encoded instruction.
- out_addr  out  32  byte address of out_word.
- err  out  1  one-cycle pulse on an illegal op or out-of-range immediate.
- err_count  out  8  saturating error counter.
- done  out  1  one-cycle pulse when a program has fully drained.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on ports clock/reset.
- Reset values: FIFO empty, out_valid=0, out_addr=BASE_ADDR, err=0, err_count=0, done=0, state=LOAD. in_ready is 1 once in LOAD.
- Reset mid-operation discards FIFO contents and any pending last.
- FSM LOAD -> DRAIN -> DONE -> LOAD:
  - LOAD: in_ready = !full. An accepted beat with in_last moves to DRAIN.
  - DRAIN: in_ready=0. Moves to DONE when the FIFO is empty.
  - DONE: single cycle. done=1, out_addr reloads BASE_ADDR, return to LOAD.
- Acceptance: in_valid & in_ready. Encoding is combinational and the word is written to the FIFO in the same edge.
- Latency: the word is visible on out_word at the earliest one cycle after acceptance.
- Output: out_word/out_addr are valid while out_valid. On out_valid & out_ready the FIFO pops and out_addr += 4 (32-bit wrap, no flag).
- Full FIFO: in_ready=0. A simultaneous push and pop when full is not possible, since ready is deasserted.
- Simultaneous push and pop when non-empty: occupancy unchanged.
- Formats:
  - R: funct7 bit30 set for sub/sra.
  - I: addi/andi/ori/xori/lw/jalr.
  - Shift-I: imm[4:0] into bits 24:20; srai sets bit30.
  - S: sw.
  - B: beq/bne.
  - U: lui.
  - J: jal.
  - Opcode and funct3 values match the CPU's decode exactly.
- Range checks:
  - I/S: -2048..2047.
  - Shift: 0..31.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: imm[31:20] must be 0.
  - Unknown op enum is also an error.
- On error: beat accepted but not enqueued; err pulses; err_count += 1, saturating at 255. An erroneous beat carrying in_last still triggers DRAIN.

Optional Feature:
- Macro: ENC_NOP_PAD_EN.
- When defined, entering DRAIN appends NOP words (32'h0000_0013) to the FIFO until the total words emitted since BASE_ADDR is a multiple of PAD_ALIGN. This stalls while the FIFO is full. done fires only after the padding drains.
- When undefined, no padding occurs and DRAIN only empties the FIFO.

Decomposition:
- Package sc_enc_pkg holds:
  - op enum (OP_ADD..OP_JALR, 5 bits);
  - opcode constants (OPC_R=7'b0110011, OPC_I=7'b0010011, OPC_LW, OPC_SW, OPC_BR, OPC_LUI, OPC_JAL, OPC_JALR);
  - funct3 constants;
  - NOP_WORD.
- Sub-module sc_enc_fifo: synchronous FIFO parameterised by DEPTH with full/empty.
- Encoding and range checks stay in the top level.

Test Plan:
- add x3,x1,x2 then in_last, with out_ready=1: out_word=32'h002081B3 at addr 0; done pulses after the FIFO drains.
- sub x5,x6,x7; addi x1,x0,-1: words 32'h407302B3 and 32'hFFF00093 at addrs 0 and 4.
- beq x1,x2,-4 -> 32'hFE208EE3. lui x5,0x12345 -> 32'h123452B7.
- addi imm=2048 and beq imm=3: no word enqueued; err pulses twice; err_count=2; out_addr unchanged.
- out_ready=0 with 6 pushes (DEPTH=4): in_ready drops after 4 accepts. Release out_ready: words emerge in order with addrs 0..20.
- ENC_NOP_PAD_EN, PAD_ALIGN=4, 1 instruction plus in_last: 3 trailing 32'h00000013 words at addrs 4, 8, 12, then done. Reset asserted mid-drain: FIFO empty, out_addr=0.
